// File: rtl/package_settings.sv
// Shared data-path sizing for the v5 signal chain.
package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/parameter_v5_peak.sv
// Default tuning and state encoding for the v5 peak detector.
package parameter_v5_peak;
    localparam int DEF_THRESHOLD = 100;
    localparam int DEF_MIN_WIDTH = 4;
    localparam int DEF_HOLDOFF   = 16;
    localparam int DEF_TS_WIDTH  = 32;
    localparam int DEF_WID_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLDOFF
    } peak_state_t;
endpackage

// File: rtl/v5_peak_out_reg.sv
// Single-entry output register with valid/ready handshake and a saturating drop counter.
// A new entry is refused (and counted) only while the held entry is stalled.
module v5_peak_out_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic [CNT_W-1:0]  drop_cnt
);
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              xfer;

    always_comb begin
        xfer       = out_vld_q & out_rdy;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        drop_cnt_d = drop_cnt_q;
        if (in_vld) begin
            if (!out_vld_q || xfer) begin
                out_vld_d = 1'b1;
                out_dat_d = in_dat;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (xfer) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_dat  = out_dat_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: rtl/v5_peak_detector.sv
// Threshold pulse detector: reports peak amplitude, its timestamp and pulse width per pulse.
// Result appears the cycle after the terminating sample; stalls hold the record and count drops.
module v5_peak_detector
    import package_settings::*;
    import parameter_v5_peak::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int MIN_WIDTH = DEF_MIN_WIDTH,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int WID_WIDTH = DEF_WID_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [SIZE_FILTER_DATA-1:0] peak_amp,
    output logic [TS_WIDTH-1:0]         peak_time,
    output logic [WID_WIDTH-1:0]        pulse_width,
    output logic [15:0]                 drop_count,
    output logic                        busy
);
    localparam int W      = SIZE_FILTER_DATA;
    localparam int HC_W   = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam int REC_W  = W + TS_WIDTH + WID_WIDTH;
    localparam logic signed [W-1:0] THR = W'(THRESHOLD);

    peak_state_t            state_q, state_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic signed [W-1:0]    max_q, max_d;
    logic [TS_WIDTH-1:0]    tmax_q, tmax_d;
    logic [WID_WIDTH-1:0]   width_q, width_d;
    logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;

    logic signed [W-1:0]    sample;
    logic                   above;
    logic                   res_vld;
    logic [REC_W-1:0]       res_dat;
    logic [REC_W-1:0]       rec_dat;

    assign sample = $signed(filter_data);
    assign above  = sample > THR;

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + 1'b1;
        max_d      = max_q;
        tmax_d     = tmax_q;
        width_d    = width_q;
        hold_cnt_d = hold_cnt_q;
        res_vld    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    state_d = ST_PULSE;
                    max_d   = sample;
                    tmax_d  = ts_q;
                    width_d = WID_WIDTH'(1);
                end
            end
            ST_PULSE: begin
                if (above) begin
                    if (width_q != '1) begin
                        width_d = width_q + 1'b1;
                    end
                    // strict compare keeps the earliest timestamp on a tie
                    if (sample > max_q) begin
                        max_d  = sample;
                        tmax_d = ts_q;
                    end
                end else if (width_q >= WID_WIDTH'(MIN_WIDTH)) begin
                    res_vld = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = HC_W'(HOLDOFF - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            max_q      <= '0;
            tmax_q     <= '0;
            width_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            max_q      <= max_d;
            tmax_q     <= tmax_d;
            width_q    <= width_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign res_dat = {max_q, tmax_q, width_q};

    v5_peak_out_reg #(
        .DATA_W (REC_W),
        .CNT_W  (16)
    ) u_out_reg (
        .clk      (clk),
        .rst      (reset),
        .in_vld   (res_vld),
        .in_dat   (res_dat),
        .out_rdy  (out_ready),
        .out_vld  (out_valid),
        .out_dat  (rec_dat),
        .drop_cnt (drop_count)
    );

    assign {peak_amp, peak_time, pulse_width} = rec_dat;
    assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_v5_peak_detector.sv
// Directed bench for v5_peak_detector: default instance plus a 4-bit timestamp instance for wrap.
module tb_v5_peak_detector;
    logic        clk = 1'b0;
    logic        reset, out_ready, out_valid, busy;
    logic [15:0] filter_data, peak_amp, drop_count;
    logic [31:0] peak_time;
    logic [7:0]  pulse_width;

    logic        reset2, out_ready2, out_valid2, busy2;
    logic [15:0] filter_data2, peak_amp2, drop_count2;
    logic [3:0]  peak_time2;
    logic [7:0]  pulse_width2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    v5_peak_detector dut (
        .clk         (clk),
        .reset       (reset),
        .filter_data (filter_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .peak_amp    (peak_amp),
        .peak_time   (peak_time),
        .pulse_width (pulse_width),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    v5_peak_detector #(.TS_WIDTH(4)) dut_w (
        .clk         (clk),
        .reset       (reset2),
        .filter_data (filter_data2),
        .out_ready   (out_ready2),
        .out_valid   (out_valid2),
        .peak_amp    (peak_amp2),
        .peak_time   (peak_time2),
        .pulse_width (pulse_width2),
        .drop_count  (drop_count2),
        .busy        (busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one sample per edge; outputs are examined 1 time unit after the edge
    task automatic feed(input int v);
        filter_data = 16'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_n(input int v, input int n);
        for (int i = 0; i < n; i++) feed(v);
    endtask

    task automatic feed2(input int v);
        filter_data2 = 16'(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        filter_data = '0; filter_data2 = '0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_amp",   peak_amp, 0);
        chk("rst_time",  peak_time, 0);
        chk("rst_width", pulse_width, 0);
        chk("rst_drop",  drop_count, 0);
        chk("rst_busy",  busy, 0);
        reset = 1'b0;

        // triangle: first sample tagged ts=10
        feed_n(0, 10);
        feed(0); feed(50); feed(120);
        chk("tri_busy", busy, 1);
        feed(200); feed(300); feed(200); feed(120);
        chk("tri_novalid", out_valid, 0);
        feed(50);
        chk("tri_valid", out_valid, 1);
        chk("tri_amp",   peak_amp, 300);
        chk("tri_time",  peak_time, 14);
        chk("tri_width", pulse_width, 5);
        chk("tri_hold_busy", busy, 1);
        feed(0);
        chk("tri_one_cycle", out_valid, 0);

        // holdoff covers ts18..33; short pulse of width 3 at ts35..37
        feed_n(0, 15);
        feed(0);
        feed_n(150, 3);
        chk("short_busy", busy, 1);
        feed(0);
        chk("short_busy_fall", busy, 0);
        chk("short_norecord", out_valid, 0);
        feed(150);
        chk("short_next_start", busy, 1);
        feed(200);

        // reset mid-pulse
        reset = 1'b1;
        #1;
        chk("midrst_busy",  busy, 0);
        chk("midrst_valid", out_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // flat top from ts=0 also proves the timestamp restarted
        feed(0); feed(200); feed(250); feed(250); feed(250); feed(180); feed(0);
        chk("flat_valid", out_valid, 1);
        chk("flat_amp",   peak_amp, 250);
        chk("flat_time",  peak_time, 2);
        chk("flat_width", pulse_width, 5);

        // holdoff ts7..22: pulse at ts12..15 must be ignored
        feed_n(0, 5);
        feed_n(200, 4);
        feed(0);
        chk("hold_ignored", out_valid, 0);
        chk("hold_busy", busy, 1);
        feed_n(0, 5);
        chk("hold_last_busy", busy, 1);
        feed(0);
        chk("hold_end_idle", busy, 0);
        feed(200); feed(300); feed(200); feed(200); feed(0);
        chk("after_hold_valid", out_valid, 1);
        chk("after_hold_amp",   peak_amp, 300);
        chk("after_hold_time",  peak_time, 24);
        chk("after_hold_width", pulse_width, 4);
        feed(0);
        chk("after_hold_xfer", out_valid, 0);

        // back-pressure: two pulses with out_ready low
        out_ready = 1'b0;
        feed_n(0, 15);
        feed(120); feed(130); feed(140); feed(150); feed(0);
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_amp",   peak_amp, 150);
        feed_n(0, 16);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_amp",   peak_amp, 150);
        feed_n(500, 4);
        feed(0);
        chk("bp_drop",       drop_count, 1);
        chk("bp_keep_valid", out_valid, 1);
        chk("bp_keep_amp",   peak_amp, 150);
        chk("bp_keep_time",  peak_time, 47);
        chk("bp_keep_width", pulse_width, 4);
        out_ready = 1'b1;
        feed(0);
        chk("bp_xfer_valid", out_valid, 0);
        chk("bp_drop_kept",  drop_count, 1);

        // negatives and 4-bit timestamp wrap on the second instance
        reset2 = 1'b0;
        for (int i = 0; i < 4; i++) feed2(-500);
        chk("neg_no_trigger", busy2, 0);
        for (int i = 0; i < 9; i++) feed2(0);
        feed2(150); feed2(200); feed2(300); feed2(400); feed2(200); feed2(0);
        chk("wrap_valid", out_valid2, 1);
        chk("wrap_amp",   peak_amp2, 400);
        chk("wrap_time",  peak_time2, 0);
        chk("wrap_width", pulse_width2, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
